// File: rtl/ceespu_pkg.sv
// rtl/ceespu_pkg.sv - shared field positions, opcode constants and opcode classifiers for ceespu decode
package ceespu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RA_MSB  = 20;
    localparam int RA_LSB  = 16;
    localparam int RB_MSB  = 15;
    localparam int RB_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcode bit that selects the immediate operand
    localparam int USE_IMM_BIT = 3;

    typedef logic [5:0] opcode_t;
    typedef logic [4:0] reg_idx_t;

    localparam opcode_t OPC_LUI       = 6'h0F;
    localparam opcode_t OPC_LOAD_LO   = 6'h20;
    localparam opcode_t OPC_LOAD_HI   = 6'h23;
    localparam opcode_t OPC_STORE_LO  = 6'h28;
    localparam opcode_t OPC_STORE_HI  = 6'h2B;
    // Branches occupy the top of the opcode space, so only a lower bound is needed
    localparam opcode_t OPC_BRANCH_LO = 6'h30;

    function automatic logic is_load(input opcode_t op);
        return (op >= OPC_LOAD_LO) && (op <= OPC_LOAD_HI);
    endfunction

    // Stores, branches and writes to r0 never update the register file
    function automatic logic writes_rd(input opcode_t op, input reg_idx_t rd);
        logic is_store;
        logic is_branch;
        is_store  = (op >= OPC_STORE_LO) && (op <= OPC_STORE_HI);
        is_branch = (op >= OPC_BRANCH_LO);
        return !(is_store || is_branch || (rd == 5'd0));
    endfunction

endpackage

// File: rtl/ceespu_immgen.sv
// rtl/ceespu_immgen.sv - immediate generator: LUI upper placement or sign-extended imm16
module ceespu_immgen
    import ceespu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [15:0]     I_imm16,
    input  opcode_t         I_opcode,
    output logic [XLEN-1:0] O_imm
);

    // LUI places imm16 in the upper half; everything else sign-extends
    always_comb begin
        if (I_opcode == OPC_LUI) begin
            O_imm = XLEN'({I_imm16, 16'h0000});
        end else begin
            O_imm = {{(XLEN-16){I_imm16[15]}}, I_imm16};
        end
    end

endmodule

// File: rtl/ceespu_decode.sv
// rtl/ceespu_decode.sv - decode stage with load-use stall, execute backpressure and flush
module ceespu_decode
    import ceespu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    input  logic [31:0]     I_inst,
    input  logic [XLEN-1:0] I_pc,
    output logic            O_ready,
    input  logic            I_flush,
    input  logic            I_ex_ready,
    output logic [4:0]      O_selA,
    output logic [4:0]      O_selB,
    output logic            O_valid,
    output logic [5:0]      O_opcode,
    output logic [4:0]      O_rd,
    output logic [XLEN-1:0] O_imm,
    output logic [XLEN-1:0] O_pc,
    output logic            O_we,
    output logic            O_is_load,
    output logic            O_use_imm
);

    opcode_t        opc;
    reg_idx_t       rd;
    reg_idx_t       ra;
    reg_idx_t       rb;
    logic [15:0]    imm16;
    logic [XLEN-1:0] imm;

    logic           hazard;
    logic           advance;
    logic           accept;

    logic            valid_q,   valid_d;
    opcode_t         opcode_q,  opcode_d;
    reg_idx_t        rd_q,      rd_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic            we_q,      we_d;
    logic            is_load_q, is_load_d;
    logic            use_imm_q, use_imm_d;

    assign opc   = I_inst[OPC_MSB:OPC_LSB];
    assign rd    = I_inst[RD_MSB:RD_LSB];
    assign ra    = I_inst[RA_MSB:RA_LSB];
    assign rb    = I_inst[RB_MSB:RB_LSB];
    assign imm16 = I_inst[IMM_MSB:IMM_LSB];

    // Register-file selects go out unregistered so read data lines up with the bundle
    assign O_selA = ra;
    assign O_selB = rb;

    ceespu_immgen #(.XLEN(XLEN)) u_immgen (
        .I_imm16  (imm16),
        .I_opcode (opc),
        .O_imm    (imm)
    );

    assign hazard  = I_valid && valid_q && is_load_q && (rd_q != 5'd0) &&
                     ((rd_q == ra) || (rd_q == rb));
    assign advance = !valid_q || I_ex_ready;
    assign O_ready = !hazard && advance && !I_flush;
    assign accept  = I_valid && O_ready;

    // Next bundle: flush kills, accept loads, advance without accept leaves a bubble, else hold
    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        we_d      = we_q;
        is_load_d = is_load_q;
        use_imm_d = use_imm_q;
        if (I_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = opc;
            rd_d      = rd;
            imm_d     = imm;
            pc_d      = I_pc;
            we_d      = writes_rd(opc, rd);
            is_load_d = is_load(opc);
            use_imm_d = opc[USE_IMM_BIT];
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    // Bundle register with asynchronous clear
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            we_q      <= we_d;
            is_load_q <= is_load_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign O_valid   = valid_q;
    assign O_opcode  = opcode_q;
    assign O_rd      = rd_q;
    assign O_imm     = imm_q;
    assign O_pc      = pc_q;
    assign O_we      = we_q;
    assign O_is_load = is_load_q;
    assign O_use_imm = use_imm_q;

endmodule
